ps2_key_rx: RTL and testbench

Device-side PS/2 keyboard receiver that turns the KEY_CLK/KEY_DATA frames driven by the keyboard into scan-code events for the CPU I/O path. It synchronizes and de-glitches both lines and deserializes the 11-bit frame (start, 8 data LSB-first, odd parity, stop). It folds the E0 (extended) and F0 (break) prefixes into flags on the following code byte. Receive-only: it never drives KEY_CLK or KEY_DATA.

---
 rtl/ps2_key_rx_if.sv | 12 +
 rtl/ps2_key_rx.sv | 133 +++++++++++++
 tb/tb_ps2_key_rx.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_rx_if.sv
// Scan-code event bundle presented by the PS/2 keyboard receiver to the CPU side.
interface ps2_key_rx_if;
  logic [7:0] data;
  logic       valid;
  logic       brk;
  logic       ext;
  logic       err;
  logic       busy;

  modport master (output data, valid, brk, ext, err, busy);
  modport slave  (input  data, valid, brk, ext, err, busy);
endinterface

// File: rtl/ps2_key_rx.sv
// Receive-only PS/2 keyboard deserializer: synchronizes and filters both lines,
// checks framing/odd parity, and folds E0/F0 prefixes into ext/brk flags.
module ps2_key_rx #(
  parameter int          FILTER  = 3,
  parameter logic [15:0] TIMEOUT = 16'd10000
) (
  input  logic        clk,
  input  logic        xrst,
  input  logic        key_clk,
  input  logic        key_data,
  ps2_key_rx_if.master kb
);

  localparam int FW = (FILTER > 1) ? $clog2(FILTER) : 1;

  typedef enum logic {IDLE, RECV} state_t;

  // Index 1 carries key_clk, index 0 carries key_data.
  logic [1:0]    sync1, sync2, filt;
  logic [FW-1:0] fcnt [2];
  logic          clk_prev;

  always_ff @(posedge clk) begin
    if (!xrst) begin
      sync1    <= '1;
      sync2    <= '1;
      filt     <= '1;
      fcnt[0]  <= '0;
      fcnt[1]  <= '0;
      clk_prev <= 1'b1;
    end else begin
      sync1    <= {key_clk, key_data};
      sync2    <= sync1;
      clk_prev <= filt[1];
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FW'(1);
        end
      end
    end
  end

  logic sample;
  logic din;
  assign sample = clk_prev & ~filt[1];
  assign din    = filt[0];

  state_t      state;
  logic [3:0]  cnt;
  logic [8:0]  shreg;
  logic [15:0] wd;
  logic        pend_brk, pend_ext;
  logic        ok;

  // shreg holds parity in bit 8 and the data byte below it when the stop bit arrives.
  assign ok = (^shreg) & din;

  always_ff @(posedge clk) begin
    if (!xrst) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      wd       <= '0;
      pend_brk <= 1'b0;
      pend_ext <= 1'b0;
      kb.data  <= '0;
      kb.valid <= 1'b0;
      kb.brk   <= 1'b0;
      kb.ext   <= 1'b0;
      kb.err   <= 1'b0;
      kb.busy  <= 1'b0;
    end else begin
      kb.valid <= 1'b0;
      kb.err   <= 1'b0;
      case (state)
        IDLE: begin
          if (sample && !din) begin
            state   <= RECV;
            kb.busy <= 1'b1;
            cnt     <= 4'd1;
            wd      <= '0;
          end
        end
        RECV: begin
          // Timeout is checked first so it wins over a coincident sample event.
          if (wd == TIMEOUT - 16'd1) begin
            state    <= IDLE;
            kb.busy  <= 1'b0;
            kb.err   <= 1'b1;
            cnt      <= '0;
            pend_brk <= 1'b0;
            pend_ext <= 1'b0;
          end else if (sample) begin
            wd <= '0;
            if (cnt == 4'd10) begin
              state   <= IDLE;
              kb.busy <= 1'b0;
              cnt     <= '0;
              if (!ok) begin
                kb.err   <= 1'b1;
                pend_brk <= 1'b0;
                pend_ext <= 1'b0;
              end else if (shreg[7:0] == 8'hF0) begin
                pend_brk <= 1'b1;
              end else if (shreg[7:0] == 8'hE0) begin
                pend_ext <= 1'b1;
              end else begin
                kb.data  <= shreg[7:0];
                kb.brk   <= pend_brk;
                kb.ext   <= pend_ext;
                kb.valid <= 1'b1;
                pend_brk <= 1'b0;
                pend_ext <= 1'b0;
              end
            end else begin
              shreg <= {din, shreg[8:1]};
              cnt   <= cnt + 4'd1;
            end
          end else begin
            wd <= wd + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Scoreboard bench for ps2_key_rx: directed frames push expected events, a monitor pops and compares.
module tb_ps2_key_rx;
  localparam logic [15:0] TO = 16'd200;
  localparam int          H  = 8;

  logic clk = 1'b0;
  logic xrst = 1'b0;
  logic key_clk = 1'b1;
  logic key_data = 1'b1;
  logic k3_clk = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   last_fall = 0;
  int   f3_valids = 0;
  int   f3_errs = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_key_rx_if kb1 ();
  ps2_key_rx_if kb3 ();

  ps2_key_rx #(.FILTER(1), .TIMEOUT(TO)) dut (
    .clk(clk), .xrst(xrst), .key_clk(key_clk), .key_data(key_data), .kb(kb1.master)
  );

  ps2_key_rx #(.FILTER(3), .TIMEOUT(TO)) dut3 (
    .clk(clk), .xrst(xrst), .key_clk(k3_clk), .key_data(key_data), .kb(kb3.master)
  );

  typedef struct packed {
    logic       e;
    logic [7:0] d;
    logic       b;
    logic       x;
  } ev_t;

  ev_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic e, input logic [7:0] d, input logic b, input logic x);
    ev_t ev;
    ev.e = e; ev.d = d; ev.b = b; ev.x = x;
    sb.push_back(ev);
  endtask

  always @(negedge clk) begin
    if (xrst && (kb1.valid || kb1.err)) begin
      ev_t ev;
      check("valid_err_exclusive", {31'd0, kb1.valid & kb1.err}, 32'd0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: valid=%0b err=%0b data=%0h expected no event", kb1.valid, kb1.err, kb1.data);
      end else begin
        ev = sb.pop_front();
        check("event_is_err", {31'd0, kb1.err}, {31'd0, ev.e});
        check("event_data", {24'd0, kb1.data}, {24'd0, ev.d});
        check("event_brk", {31'd0, kb1.brk}, {31'd0, ev.b});
        check("event_ext", {31'd0, kb1.ext}, {31'd0, ev.x});
      end
    end
    if (xrst && kb3.valid) f3_valids++;
    if (xrst && kb3.err)   f3_errs++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    key_data = b;
    wait_cyc(H);
    key_clk = 1'b0;
    last_fall = cyc;
    wait_cyc(H);
    key_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(stop);
    key_data = 1'b1;
    wait_cyc(20);
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, ~^b, 1'b1);
  endtask

  initial begin
    int got;
    int hi;
    wait_cyc(4);
    check("rst_data", {24'd0, kb1.data}, 32'd0);
    check("rst_flags", {26'd0, kb1.valid, kb1.brk, kb1.ext, kb1.err, kb1.busy, 1'b0}, 32'd0);
    xrst = 1'b1;
    wait_cyc(4);

    push(1'b0, 8'h1C, 1'b0, 1'b0);
    good(8'h1C);
    check("busy_after_frame", {31'd0, kb1.busy}, 32'd0);

    push(1'b0, 8'h14, 1'b1, 1'b0);
    good(8'hF0);
    good(8'h14);

    push(1'b0, 8'h75, 1'b1, 1'b1);
    good(8'hE0);
    good(8'hF0);
    good(8'h75);
    push(1'b0, 8'h1C, 1'b0, 1'b0);
    good(8'h1C);

    push(1'b1, 8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b1);
    push(1'b1, 8'h1C, 1'b0, 1'b0);
    send_frame(8'h14, 1'b1, 1'b0);

    good(8'hF0);
    push(1'b1, 8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b1);
    push(1'b0, 8'h14, 1'b0, 1'b0);
    good(8'h14);

    push(1'b0, 8'h1C, 1'b0, 1'b1);
    good(8'hE0);
    good(8'hE0);
    good(8'h1C);

    key_data = 1'b1;
    send_bit(1'b1);
    wait_cyc(6);
    check("idle_high_data_ignored", {31'd0, kb1.busy}, 32'd0);

    push(1'b1, 8'h1C, 1'b0, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    key_data = 1'b1;
    check("busy_mid_frame", {31'd0, kb1.busy}, 32'd1);
    got = -1;
    for (int k = 0; k < int'(TO) + 60; k++) begin
      @(negedge clk);
      if (kb1.err) begin
        got = cyc;
        break;
      end
    end
    check("timeout_delay", got - last_fall, int'(TO) + 4);
    wait_cyc(1);
    check("busy_after_timeout", {31'd0, kb1.busy}, 32'd0);
    wait_cyc(10);
    push(1'b0, 8'h14, 1'b0, 1'b0);
    good(8'h14);

    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    check("busy_before_reset", {31'd0, kb1.busy}, 32'd1);
    xrst = 1'b0;
    wait_cyc(2);
    xrst = 1'b1;
    key_data = 1'b1;
    wait_cyc(1);
    check("data_after_reset", {24'd0, kb1.data}, 32'd0);
    check("busy_after_reset", {31'd0, kb1.busy}, 32'd0);
    wait_cyc(10);
    push(1'b0, 8'h1C, 1'b0, 1'b0);
    good(8'h1C);

    key_data = 1'b0;
    wait_cyc(6);
    k3_clk = 1'b0;
    wait_cyc(1);
    k3_clk = 1'b1;
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (kb3.busy) hi++;
    end
    check("glitch_no_start", hi, 0);
    k3_clk = 1'b0;
    wait_cyc(8);
    k3_clk = 1'b1;
    wait_cyc(4);
    check("f3_long_pulse_starts", {31'd0, kb3.busy}, 32'd1);
    key_data = 1'b1;
    wait_cyc(int'(TO) + 20);
    check("f3_busy_after_timeout", {31'd0, kb3.busy}, 32'd0);

    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    check("f3_valid_count", f3_valids, 0);
    check("f3_err_count", f3_errs, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
